ack_event_fifo: RTL and testbench
=================================

# ack_event_fifo

Downstream completion queue for the one-hot ACK bus arbiter. Every cycle the arbiter asserts its ack event, this block captures the 2-bit winning source ID into a small FIFO. The control block drains the FIFO through a valid/ready handshake, so completions from MEM, SHA, AES and CTRL are retired in grant order and none is lost while the controller is busy. It also flags overflow and, optionally, keeps per-source completion counters.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, width of each per-source counter (stats build only).

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ack_event  input  1  arbiter grant pulse; each high cycle is one completion.
- winner_source_id  input  2  granted source (00 MEM, 01 SHA, 10 AES, 11 CTRL); sampled only when ack_event=1.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_source_id  output  2  head entry ID; 2'b00 when empty.
- fifo_full  output  1  level == DEPTH.
- fifo_empty  output  1  level == 0.
- fifo_level  output  $clog2(DEPTH)+1  current entry count.
- overflow  output  1  sticky: a completion was dropped.
- overflow_clr  input  1  clears overflow.
- cnt_mem, cnt_sha, cnt_aes, cnt_ctrl  output  CNT_W each  per-source accepted-completion counts (stats build only).
- stats_clr  input  1  zeroes all counters (stats build only).

## Operation
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a separate level counter.
- push = ack_event && (!fifo_full || pop).
- pop = out_valid && out_ready.
- Push writes winner_source_id at the write pointer, then increments the write pointer.
- Pop increments the read pointer.
- Level update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: the push is accepted and the level stays at DEPTH.
- Full without pop: ack_event drops the ID and sets overflow. Pointers and level are unchanged.
- Pop when empty is impossible, since out_valid=0; out_ready is ignored.
- out_valid = !fifo_empty.
- out_source_id = mem[rd_ptr] when non-empty, else 2'b00.
- overflow sets on a dropped push and clears on overflow_clr. If both happen in the same cycle, set wins.
- No other state machine: the block is a pure push/pop FIFO with flag logic.
- Reset: pointers, level and overflow go to 0. Outputs: out_valid=0, out_source_id=00, fifo_empty=1, fifo_full=0, fifo_level=0, overflow=0, counters=0.
- Reset asserted mid-operation discards all entries immediately (asynchronous). No partial state survives.

## Timing
- Latency from push to visibility: ack_event at edge N makes out_valid=1 after edge N. There is no combinational bypass from ack_event to out_valid.
- Pop takes effect at the edge where out_valid && out_ready. The next entry, or empty, appears after that edge.
- Throughput: one push and one pop per cycle, sustained.
- Flags, level and counters are registered and update on the same edge as the pointers.
- out_source_id is a combinational read of registered storage at rd_ptr.

## Configuration
- ACK_FIFO_STATS_EN defined: cnt_mem, cnt_sha, cnt_aes, cnt_ctrl and stats_clr exist.
  - The counter selected by winner_source_id increments on every accepted push; dropped pushes are not counted.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - stats_clr zeroes all counters; if it coincides with a push, clear wins.
- ACK_FIFO_STATS_EN undefined: those ports and counters are absent. FIFO behaviour is identical.

## Test plan
- Basic order: with out_ready=0, pulse ack_event with IDs 01, 10, 11. Expect level=3. Then hold out_ready=1 and expect out_source_id 01, 10, 11 on consecutive cycles, followed by empty=1.
- Full and drop: with DEPTH=4 and out_ready=0, push 00, 01, 10, 11. Expect full=1. A fifth push with 01 sets overflow=1, level stays 4, and the head is still 00.
- Full with simultaneous pop: when full, push 10 while out_ready=1. Expect overflow unchanged, level=4, and 10 appearing as the tail after three more pops.
- Wrap-around: run 10 push/pop pairs with rotating IDs. Expect output order to match input order across pointer wrap, with level never above 1.
- Reset mid-operation: with level=3, pulse rst_n low asynchronously between edges. Expect out_valid=0, level=0 and overflow=0 immediately, with no stale entries after release.
- Stats (ACK_FIFO_STATS_EN, CNT_W=2): push SHA five times with pops in between. Expect cnt_sha=3 (saturated), other counters 0. Then stats_clr gives all counters 0.

Source files
------------

// File: rtl/ack_event_fifo.sv
// Completion queue for ACK arbiter grants: circular-buffer FIFO with sticky overflow.
// Define ACK_FIFO_STATS_EN to add saturating per-source completion counters.
module ack_event_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ack_event,
  input  logic [1:0]                 winner_source_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_source_id,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  input  logic                       overflow_clr
`ifdef ACK_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]           cnt_mem,
  output logic [CNT_W-1:0]           cnt_sha,
  output logic [CNT_W-1:0]           cnt_aes,
  output logic [CNT_W-1:0]           cnt_ctrl,
  input  logic                       stats_clr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("ack_event_fifo: DEPTH must be a power of two >= 2, CNT_W >= 1");
  end

  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  assign fifo_empty    = (level_q == '0);
  assign fifo_full     = (level_q == LW'(DEPTH));
  assign fifo_level    = level_q;
  assign overflow      = ovf_q;
  assign out_valid     = !fifo_empty;
  assign out_source_id = fifo_empty ? 2'b00 : mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a full FIFO can still accept.
  assign pop  = out_valid && out_ready;
  assign push = ack_event && (!fifo_full || pop);
  assign drop = ack_event && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop)              ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
    end else if (push) begin
      mem_q[wr_ptr_q] <= winner_source_id;
    end
  end

`ifdef ACK_FIFO_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
    if (stats_clr) begin
      for (int i = 0; i < 4; i++) cnt_d[i] = '0;
    end else if (push && cnt_q[winner_source_id] != '1) begin
      cnt_d[winner_source_id] = cnt_q[winner_source_id] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_mem  = cnt_q[0];
  assign cnt_sha  = cnt_q[1];
  assign cnt_aes  = cnt_q[2];
  assign cnt_ctrl = cnt_q[3];
`endif

endmodule

// File: tb/tb_ack_event_fifo.sv
// Bench for ack_event_fifo: vector table, directed corners, random vs queue model.
// Stats checks are compiled in when ACK_FIFO_STATS_EN is defined.
module tb_ack_event_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ack_event;
  logic [1:0] winner_source_id;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_source_id;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       overflow_clr;
`ifdef ACK_FIFO_STATS_EN
  logic [CW-1:0] cnt_mem, cnt_sha, cnt_aes, cnt_ctrl;
  logic          stats_clr;
`endif

  ack_event_fifo #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ack_event(ack_event),
    .winner_source_id(winner_source_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_source_id(out_source_id),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
`ifdef ACK_FIFO_STATS_EN
    ,
    .cnt_mem(cnt_mem),
    .cnt_sha(cnt_sha),
    .cnt_aes(cnt_aes),
    .cnt_ctrl(cnt_ctrl),
    .stats_clr(stats_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ack;
    logic [1:0] id;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] hid;
    logic [2:0] lvl;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  mq[$];
  logic        movf;
  int unsigned mcnt[4];

  function automatic vec_t mk(logic a, logic [1:0] i, logic r, logic c,
                              logic v, logic [1:0] h, logic [2:0] l,
                              logic f, logic o);
    vec_t t;
    t.ack = a; t.id = i; t.rdy = r; t.clr = c;
    t.v = v; t.hid = h; t.lvl = l; t.full = f; t.ovf = o;
    return t;
  endfunction

  function automatic logic [15:0] pk(logic v, logic [1:0] h, logic [2:0] l,
                                     logic f, logic e, logic o);
    return {7'b0, v, h, l, f, e, o};
  endfunction

  function automatic logic [15:0] dut_pk();
    return pk(out_valid, out_source_id, fifo_level, fifo_full, fifo_empty, overflow);
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(logic a, logic [1:0] i, logic r, logic c);
    ack_event = a; winner_source_id = i; out_ready = r; overflow_clr = c;
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 1'b0;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
  endtask

  // Model: pop is decided on the pre-edge occupancy, then push, then overflow.
  task automatic model_step(logic a, logic [1:0] i, logic r, logic c, logic sc);
    bit p_pop, p_push;
    p_pop  = (mq.size() > 0) && r;
    p_push = a && ((mq.size() < DEPTH) || p_pop);
    if (p_pop) void'(mq.pop_front());
    if (p_push) mq.push_back(i);
    if (a && !p_push) movf = 1'b1;
    else if (c) movf = 1'b0;
    if (sc) begin
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
    end else if (p_push && mcnt[i] < (1 << CW) - 1) begin
      mcnt[i]++;
    end
  endtask

  function automatic logic [15:0] model_pk();
    logic [1:0] h;
    h = (mq.size() > 0) ? mq[0] : 2'b00;
    return pk(mq.size() > 0, h, 3'(mq.size()), mq.size() == DEPTH,
              mq.size() == 0, movf);
  endfunction

  task automatic do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
`ifdef ACK_FIFO_STATS_EN
    stats_clr = 1'b0;
`endif
    rst_n = 1'b0;
    #2;
    chk("reset_state", dut_pk(), pk(0, 2'b00, 3'd0, 0, 1, 0));
`ifdef ACK_FIFO_STATS_EN
    chk("reset_cnt", {8'b0, cnt_mem, cnt_sha, cnt_aes, cnt_ctrl}, 16'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0);
`ifdef ACK_FIFO_STATS_EN
    stats_clr = 1'b0;
`endif
    //          ack id     rdy clr  v  head   lvl   f  ovf
    tbl.push_back(mk(1, 2'b01, 0, 0, 1, 2'b01, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 1, 2'b01, 3'd2, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 2'b01, 3'd3, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b10, 3'd2, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b11, 3'd1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 3'd0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 1, 2'b00, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 0, 1, 2'b00, 3'd2, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 1, 2'b00, 3'd3, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 2'b00, 3'd4, 1, 0));
    tbl.push_back(mk(1, 2'b01, 0, 0, 1, 2'b00, 3'd4, 1, 1));
    tbl.push_back(mk(1, 2'b10, 1, 0, 1, 2'b01, 3'd4, 1, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b10, 3'd3, 0, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b11, 3'd2, 0, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b10, 3'd1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 3'd0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 3'd0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 1, 2'b00, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 0, 1, 2'b00, 3'd2, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 0, 1, 2'b00, 3'd3, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 1, 2'b00, 3'd4, 1, 0));
    tbl.push_back(mk(1, 2'b01, 0, 1, 1, 2'b00, 3'd4, 1, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b01, 3'd3, 0, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b10, 3'd2, 0, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 1, 2'b11, 3'd1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 1, 1, 0, 2'b00, 3'd0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 1, 0, 1, 2'b10, 3'd1, 0, 0));
    tbl.push_back(mk(1, 2'b11, 1, 0, 1, 2'b11, 3'd1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 3'd0, 0, 0));

    do_reset();

    foreach (tbl[n]) begin
      drive(tbl[n].ack, tbl[n].id, tbl[n].rdy, tbl[n].clr);
      @(negedge clk);
      chk($sformatf("vec%0d", n), dut_pk(),
          pk(tbl[n].v, tbl[n].hid, tbl[n].lvl, tbl[n].full, !tbl[n].v, tbl[n].ovf));
    end

    // Ten push/pop pairs across pointer wrap; level must stay at 1.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2'(k), 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("wrap%0d", k), dut_pk(), pk(1, 2'(k), 3'd1, 0, 0, 0));
    end
    drive(1'b0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    chk("wrap_drain", dut_pk(), pk(0, 2'b00, 3'd0, 0, 1, 0));

    // Asynchronous reset with three entries and overflow set.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("pre_async_rst", dut_pk(), pk(1, 2'b01, 3'd3, 0, 0, 1));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", dut_pk(), pk(0, 2'b00, 3'd0, 0, 1, 0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_push", dut_pk(), pk(1, 2'b10, 3'd1, 0, 0, 0));

`ifdef ACK_FIFO_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b01, 1'b1, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("cnt_sat", {8'b0, cnt_mem, cnt_sha, cnt_aes, cnt_ctrl},
        {8'b0, 2'd0, 2'd3, 2'd0, 2'd0});
    drive(1'b1, 2'b10, 1'b0, 1'b0);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("cnt_clr", {8'b0, cnt_mem, cnt_sha, cnt_aes, cnt_ctrl}, 16'h0);
`endif

    // Randomised traffic against the queue model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic a, r, c, sc;
      logic [1:0] i;
      a  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 45);
      c  = ($urandom_range(0, 99) < 6);
      sc = ($urandom_range(0, 99) < 3);
      i  = 2'($urandom_range(0, 3));
      drive(a, i, r, c);
`ifdef ACK_FIFO_STATS_EN
      stats_clr = sc;
`endif
      model_step(a, i, r, c,
`ifdef ACK_FIFO_STATS_EN
                 sc
`else
                 1'b0
`endif
                 );
      @(negedge clk);
      chk($sformatf("rnd%0d", k), dut_pk(), model_pk());
`ifdef ACK_FIFO_STATS_EN
      chk($sformatf("rnd_cnt%0d", k), {8'b0, cnt_mem, cnt_sha, cnt_aes, cnt_ctrl},
          {8'b0, 2'(mcnt[0]), 2'(mcnt[1]), 2'(mcnt[2]), 2'(mcnt[3])});
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
